// File: rtl/cpu_pkg.sv
// Shared core definitions: next-PC select encodings and the default PC width.
package cpu_pkg;

  localparam int PC_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    BR_SEQ = 2'd0,
    BR_TGT = 2'd1,
    BR_RET = 2'd2,
    BR_RSV = 2'd3
  } br_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Full pushes overwrite the oldest entry; an empty
// stack presents RESET_VAL on top. ovf/unf are single-cycle pulses for this edge.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int             W         = PC_W_DEFAULT,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0] cnt_q, cnt_d;

  assign ptr_inc = ptr_q + 1'b1;
  assign top     = (cnt_q == '0) ? RESET_VAL : mem_q[ptr_q];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (push && pop) begin
      // Replace the top in place; the entry count does not move.
      if (cnt_q == '0) unf = 1'b1;
      else             mem_d[ptr_q] = push_data;
    end else if (push) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = push_data;
      if (cnt_q == CW'(DEPTH)) ovf   = 1'b1;
      else                     cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (cnt_q == '0) begin
        unf = 1'b1;
      end else begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and return-address unit. Define FETCH_RAS_EN for a RAS_DEPTH-entry
// return-address stack; otherwise a single link register holds the return address.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      branchSel,
  input  logic [PC_W-1:0] target,
  input  logic            lr_we,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic [PC_W-1:0] lr_out,
  output logic            ras_ovf,
  output logic            ras_unf,
  output logic            bad_sel
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            bad_sel_q, bad_sel_d;
  logic            push;

  assign push     = lr_we & ~stall;
  assign pc       = pc_q;
  assign pc_plus2 = pc_q + PC_W'(2);
  assign bad_sel  = bad_sel_q;

`ifdef FETCH_RAS_EN
  logic pop, ovf_pulse, unf_pulse;
  logic ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;

  assign pop = (branchSel == BR_RET) & ~stall;

  ras_stack #(
    .W         (PC_W),
    .DEPTH     (RAS_DEPTH),
    .RESET_VAL (RESET_PC)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus2),
    .top       (lr_out),
    .ovf       (ovf_pulse),
    .unf       (unf_pulse)
  );

  always_comb begin
    ras_ovf_d = ras_ovf_q | ovf_pulse;
    ras_unf_d = ras_unf_q | unf_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;
`else
  logic [PC_W-1:0] lr_q, lr_d;

  always_comb lr_d = push ? pc_plus2 : lr_q;

  always_ff @(posedge clk) begin
    if (rst) lr_q <= RESET_PC;
    else     lr_q <= lr_d;
  end

  assign lr_out  = lr_q;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  // An empty stack already presents RESET_PC on lr_out, so returns need no special case.
  always_comb begin
    pc_d      = pc_q;
    bad_sel_d = bad_sel_q;
    if (!stall) begin
      case (br_sel_e'(branchSel))
        BR_TGT:  pc_d = target & ~PC_W'(1);
        BR_RET:  pc_d = lr_out;
        BR_RSV: begin
          pc_d      = pc_plus2;
          bad_sel_d = 1'b1;
        end
        default: pc_d = pc_plus2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      bad_sel_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      bad_sel_q <= bad_sel_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, hand-written call/return sequences
// and randomized cycles checked against a queue-based return-address model.
module tb_fetch_pc_unit;

  localparam int DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  branchSel = 2'd0;
  logic [15:0] target = 16'h0000;
  logic        lr_we = 1'b0;
  logic [15:0] pc, pc_plus2, lr_out;
  logic        ras_ovf, ras_unf, bad_sel;

  fetch_pc_unit #(
    .PC_W      (16),
    .RESET_PC  (RST_PC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .branchSel (branchSel),
    .target    (target),
    .lr_we     (lr_we),
    .pc        (pc),
    .pc_plus2  (pc_plus2),
    .lr_out    (lr_out),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .bad_sel   (bad_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: return addresses kept as a queue, newest at the back.
  logic [15:0] m_pc = RST_PC;
  logic [15:0] m_lr = RST_PC;
  logic [15:0] m_q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_bad = 1'b0;

  function automatic logic [15:0] m_top();
    if (RAS) return (m_q.size() != 0) ? m_q[m_q.size()-1] : RST_PC;
    return m_lr;
  endfunction

  task automatic model_edge();
    logic [15:0] pp2, np, tp;
    if (rst) begin
      m_pc = RST_PC; m_lr = RST_PC; m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
    end else if (!stall) begin
      pp2 = m_pc + 16'd2;
      tp  = m_top();
      case (branchSel)
        2'd1:    np = {target[15:1], 1'b0};
        2'd2:    np = tp;
        default: np = pp2;
      endcase
      if (branchSel == 2'd3) m_bad = 1'b1;
`ifdef FETCH_RAS_EN
      if (lr_we && branchSel == 2'd2) begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else m_q[m_q.size()-1] = pp2;
      end else if (lr_we) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_q.push_back(pp2);
      end else if (branchSel == 2'd2) begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else void'(m_q.pop_back());
      end
`else
      if (lr_we) m_lr = pp2;
`endif
      m_pc = np;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic r, input logic s, input logic [1:0] sel,
                      input logic [15:0] tgt, input logic w);
    rst = r; stall = s; branchSel = sel; target = tgt; lr_we = w;
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus2", pc_plus2, m_pc + 16'd2);
    chk("lr_out", lr_out, m_top());
    chkb("bad_sel", bad_sel, m_bad);
    chkb("ras_ovf", ras_ovf, m_ovf);
    chkb("ras_unf", ras_unf, m_unf);
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic [1:0]  sel;
    logic [15:0] tgt;
    logic        w;
    logic [15:0] e_pc;
    logic [15:0] e_lr;
    logic        e_bad;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] sel,
                              input logic [15:0] tgt, input logic w,
                              input logic [15:0] e_pc, input logic [15:0] e_lr,
                              input logic e_bad);
    vec_t v;
    v.r = r; v.s = s; v.sel = sel; v.tgt = tgt; v.w = w;
    v.e_pc = e_pc; v.e_lr = e_lr; v.e_bad = e_bad;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [15:0] lr_after;
    logic [15:0] exp_pc;
    int          v;
    logic        r, s, w;
    logic [1:0]  sel;

    // After the first return the stack is empty again; the link register keeps 0012.
    lr_after = RAS ? 16'h0000 : 16'h0012;
    vt.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0002, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0004, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0006, 16'h0000, 0));
    vt.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0006, 16'h0000, 0));
    vt.push_back(mk(0, 1, 1, 16'h1234, 1, 16'h0006, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0008, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h000A, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h000C, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h000E, 16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0010, 16'h0000, 0));
    vt.push_back(mk(0, 0, 1, 16'h0041, 1, 16'h0040, 16'h0012, 0));
    vt.push_back(mk(0, 0, 2, 16'h0000, 0, 16'h0012, lr_after, 0));
    vt.push_back(mk(0, 0, 1, 16'hFFFF, 0, 16'hFFFE, lr_after, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, lr_after, 0));
    vt.push_back(mk(0, 0, 3, 16'h0000, 0, 16'h0002, lr_after, 1));
    vt.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0002, lr_after, 1));

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].s, vt[i].sel, vt[i].tgt, vt[i].w);
      chk("tbl_pc", pc, vt[i].e_pc);
      chk("tbl_lr", lr_out, vt[i].e_lr);
      chkb("tbl_bad", bad_sel, vt[i].e_bad);
    end

    // Push and return in the same cycle with 0300 on top at pc 0050.
    step(1, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 16'h02FE, 0);
    step(0, 0, 1, 16'h0050, 1);
    chk("swap_setup_lr", lr_out, 16'h0300);
    step(0, 0, 2, 16'h0000, 1);
    chk("swap_pc", pc, 16'h0300);
    chk("swap_lr", lr_out, 16'h0052);
    step(0, 0, 2, 16'h0000, 0);
    chk("swap_ret_pc", pc, 16'h0052);
    chkb("swap_no_unf", ras_unf, 1'b0);

    // Five nested calls, then five returns.
    step(1, 0, 0, 16'h0000, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 16'(i * 256), 0);
      step(0, 0, 1, 16'(16'h1000 + i * 16), 1);
    end
    chkb("nest_ovf", ras_ovf, RAS);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 2, 16'h0000, 0);
      exp_pc = RAS ? 16'((5 - k) * 256 + 2) : 16'h0502;
      chk("nest_ret_pc", pc, exp_pc);
    end
    step(0, 0, 2, 16'h0000, 0);
    chk("nest_ret5_pc", pc, RAS ? 16'h0000 : 16'h0502);
    chkb("nest_unf", ras_unf, RAS);

    // Reset wins over stall and an in-flight push/return.
    step(0, 0, 3, 16'h0000, 0);
    step(0, 0, 1, 16'h0700, 1);
    step(1, 1, 2, 16'h0000, 1);
    chk("rst_pc", pc, RST_PC);
    chk("rst_lr", lr_out, RST_PC);
    chkb("rst_bad", bad_sel, 1'b0);
    chkb("rst_ovf", ras_ovf, 1'b0);
    chkb("rst_unf", ras_unf, 1'b0);

    // Randomized cycles against the model.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 4) == 0);
      v = $urandom_range(0, 15);
      sel = (v < 7) ? 2'd0 : (v < 11) ? 2'd1 : (v < 15) ? 2'd2 : 2'd3;
      w = ($urandom_range(0, 2) == 0);
      step(r, s, sel, 16'($urandom), w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
